// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one line-wide memory port between the
// instruction cache and the data cache. One transaction is in flight at a time.
// Every transaction ends with a one-cycle TURN gap so the served cache can drop its
// request before the next arbitration. A wait-cycle watchdog guards each grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1023   // must be >= 1
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  // instruction cache side
  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [DATA_W-1:0] ic_mem_wdata,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  // data cache side
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  // shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StGrantIc, StGrantDc, StTurn} state_e;

  // last_grant encoding: 1 = data cache served last, 0 = instruction cache
  state_e          state_q, state_d;
  logic            last_dc_q, last_dc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic ic_pend, dc_pend, ic_both, dc_both;
  logic gnt_pend, gnt_both, timeout_hit;

  assign ic_pend = ic_mem_read | ic_mem_write;
  assign dc_pend = dc_mem_read | dc_mem_write;
  assign ic_both = ic_mem_read & ic_mem_write;
  assign dc_both = dc_mem_read & dc_mem_write;

  assign gnt_pend    = (state_q == StGrantIc) ? ic_pend : dc_pend;
  assign gnt_both    = (state_q == StGrantIc) ? ic_both : dc_both;
  // The cycle whose increment would bring the counter to TIMEOUT is the last one allowed
  assign timeout_hit = (cnt_q >= CntW'(TIMEOUT - 1));

  assign arb_err = err_q;

  // Memory port and cache responses mirror the granted requester; zero otherwise
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_mem_rdata = '0;
    ic_mem_ready = 1'b0;
    dc_mem_rdata = '0;
    dc_mem_ready = 1'b0;
    if (state_q == StGrantIc) begin
      // read+write together is executed as a write
      mem_read     = ic_mem_read & ~ic_mem_write;
      mem_write    = ic_mem_write;
      mem_addr     = ic_mem_addr;
      mem_wdata    = ic_mem_wdata;
      ic_mem_rdata = mem_rdata;
      ic_mem_ready = mem_ready;
    end else if (state_q == StGrantDc) begin
      mem_read     = dc_mem_read & ~dc_mem_write;
      mem_write    = dc_mem_write;
      mem_addr     = dc_mem_addr;
      mem_wdata    = dc_mem_wdata;
      dc_mem_rdata = mem_rdata;
      dc_mem_ready = mem_ready;
    end
  end

  // Next-state: arbitration, completion, abandon and watchdog handling
  always_comb begin
    state_d   = state_q;
    last_dc_d = last_dc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ic_pend && (!dc_pend || last_dc_q)) begin
          state_d = StGrantIc;
        end else if (dc_pend) begin
          state_d = StGrantDc;
        end
      end
      StGrantIc, StGrantDc: begin
        cnt_d = (cnt_q == CntW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        if (gnt_both) begin
          err_d = 1'b1;
        end
        if (mem_ready) begin
          state_d   = StTurn;
          last_dc_d = (state_q == StGrantDc);
        end else if (!gnt_pend || timeout_hit) begin
          // requester walked away or memory never answered
          state_d = StTurn;
          err_d   = 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset favours the instruction cache on the first tie
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q   <= StIdle;
      last_dc_q <= 1'b1;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge. Expected output vectors come from
// exp_grant(), which encodes the mirroring rules for whichever cache is served.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 7;
  localparam int unsigned OW = 4 + AW + 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_rd, ic_wr, dc_rd, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] ic_wdata, dc_wdata;
  logic [DW-1:0] ic_rdata, dc_rdata;
  logic          ic_ready, dc_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          arb_err;
  logic [OW-1:0] all_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .ic_mem_read  (ic_rd),
    .ic_mem_write (ic_wr),
    .ic_mem_addr  (ic_addr),
    .ic_mem_wdata (ic_wdata),
    .ic_mem_rdata (ic_rdata),
    .ic_mem_ready (ic_ready),
    .dc_mem_read  (dc_rd),
    .dc_mem_write (dc_wr),
    .dc_mem_addr  (dc_addr),
    .dc_mem_wdata (dc_wdata),
    .dc_mem_rdata (dc_rdata),
    .dc_mem_ready (dc_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .arb_err      (arb_err)
  );

  assign all_out = {mem_read, mem_write, mem_addr, mem_wdata, ic_ready, dc_ready,
                    ic_rdata, dc_rdata};

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected outputs while one cache owns the memory port
  function automatic logic [OW-1:0] exp_grant(input bit to_dc, input bit rd, input bit wr,
                                              input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                              input bit rdy, input logic [DW-1:0] rdat);
    logic [DW-1:0] zero_line;
    zero_line = '0;
    if (to_dc) return {rd & !wr, wr, a, wd, 1'b0, rdy, zero_line, rdat};
    return {rd & !wr, wr, a, wd, rdy, 1'b0, rdat, zero_line};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_rd = 0; ic_wr = 0; dc_rd = 0; dc_wr = 0;
    ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_ready = 1'b1;
    mem_rdata = rnd_line();
    #3;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_out); end
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", arb_err); end
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle: got %h want 0", all_out); end
    tick();
  endtask

  task automatic test_dc_read();
    logic [DW-1:0] rd;
    dc_rd = 1; dc_addr = 28'h0000010; dc_wdata = rnd_line();
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL dcrd_idle: got %h want 0", all_out); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      mem_ready = (k == 4);
      rd = (k == 4) ? {16{8'hAA}} : rnd_line();
      mem_rdata = rd;
      @(negedge clk);
      checks++;
      if (all_out !== exp_grant(1, 1, 0, 28'h0000010, dc_wdata, k == 4, rd)) begin
        errors++;
        $display("FAIL dcrd_grant%0d: got %h want %h", k, all_out,
                 exp_grant(1, 1, 0, 28'h0000010, dc_wdata, k == 4, rd));
      end
      tick();
    end
    dc_rd = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL dcrd_turn: got %h want 0", all_out); end
    tick();
  endtask

  task automatic test_tie();
    logic [DW-1:0] rd;
    do_reset();
    ic_rd = 1; ic_addr = AW'($urandom); ic_wdata = rnd_line();
    dc_wr = 1; dc_addr = AW'($urandom); dc_wdata = rnd_line();
    tick();
    rd = rnd_line(); mem_rdata = rd; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(0, 1, 0, ic_addr, ic_wdata, 1, rd)) begin
      errors++; $display("FAIL tie_ic_first: got %h want %h", all_out,
                         exp_grant(0, 1, 0, ic_addr, ic_wdata, 1, rd));
    end
    tick();
    ic_rd = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL tie_turn: got %h want 0", all_out); end
    tick();
    tick();
    rd = rnd_line(); mem_rdata = rd; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(1, 0, 1, dc_addr, dc_wdata, 1, rd)) begin
      errors++; $display("FAIL tie_dc_second: got %h want %h", all_out,
                         exp_grant(1, 0, 1, dc_addr, dc_wdata, 1, rd));
    end
    tick();
    dc_wr = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit last_dc, w_dc;
    int lat;
    logic [DW-1:0] rd;
    last_dc = 1'b1;  // the DC write was served last
    ic_rd = 1; ic_addr = AW'($urandom); ic_wdata = rnd_line();
    dc_wr = 1; dc_addr = AW'($urandom); dc_wdata = rnd_line();
    for (int t = 0; t < 4; t++) begin
      w_dc = !last_dc;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL b2b_gap%0d: got %h want 0", t, all_out); end
      tick();
      lat = $urandom_range(0, 3);
      for (int k = 0; k <= lat; k++) begin
        rd = rnd_line(); mem_rdata = rd; mem_ready = (k == lat);
        @(negedge clk);
        checks++;
        if (all_out !== exp_grant(w_dc, !w_dc, w_dc, w_dc ? dc_addr : ic_addr,
                                  w_dc ? dc_wdata : ic_wdata, k == lat, rd)) begin
          errors++;
          $display("FAIL b2b_grant%0d: got %h want %s", t, all_out, w_dc ? "DC" : "IC");
        end
        tick();
      end
      mem_ready = 0;
      if (t == 3) begin ic_rd = 0; dc_wr = 0; end
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL b2b_turn%0d: got %h want 0", t, all_out); end
      tick();
      last_dc = w_dc;
    end
  endtask

  task automatic test_spurious_ready();
    logic [DW-1:0] rd;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1; mem_rdata = rnd_line();
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL spurious%0d: got %h want 0", k, all_out); end
      tick();
    end
    mem_ready = 0;
    dc_rd = 1; dc_addr = AW'($urandom); dc_wdata = rnd_line();
    tick();
    rd = rnd_line(); mem_rdata = rd; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(1, 1, 0, dc_addr, dc_wdata, 1, rd)) begin
      errors++; $display("FAIL spurious_then_grant: got %h want DC grant", all_out);
    end
    tick();
    dc_rd = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_timeout();
    dc_rd = 1; dc_addr = AW'($urandom); dc_wdata = rnd_line();
    tick();
    for (int k = 1; k <= int'(TO); k++) begin
      mem_rdata = rnd_line();
      @(negedge clk);
      checks++;
      if (all_out !== exp_grant(1, 1, 0, dc_addr, dc_wdata, 0, mem_rdata) || arb_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: got %h err %b want DC grant err 0",
                           k, all_out, arb_err);
      end
      tick();
    end
    dc_rd = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0 || arb_err !== 1'b1) begin
      errors++; $display("FAIL timeout_turn: got %h err %b want 0 err 1", all_out, arb_err);
    end
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    checks++;
    if (all_out !== '0 || arb_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %h err %b want 0 err 1", all_out, arb_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ic_rd = 1; ic_addr = AW'($urandom); ic_wdata = rnd_line();
    tick();
    mem_rdata = rnd_line();
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(0, 1, 0, ic_addr, ic_wdata, 0, mem_rdata)) begin
      errors++; $display("FAIL rstmid_grant: got %h want IC grant", all_out);
    end
    #2;
    mem_ready = 1;
    rst_n = 0;
    #1;
    checks++;
    if (all_out !== '0 || arb_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got %h err %b want 0 err 0", all_out, arb_err);
    end
    tick();
    ic_rd = 0; mem_ready = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (all_out !== '0 || arb_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: got %h err %b want 0 err 0", all_out, arb_err);
    end
    tick();
  endtask

  task automatic test_random();
    bit last_dc, w_dc, w_rd, w_wr;
    int p, lat;
    logic [DW-1:0] rd;
    last_dc = 1'b1;  // fresh from reset
    for (int t = 0; t < 40; t++) begin
      p = $urandom_range(1, 3);
      ic_wr = $urandom_range(0, 1); ic_rd = !ic_wr;
      dc_wr = $urandom_range(0, 1); dc_rd = !dc_wr;
      if (p[0] == 1'b0) begin ic_rd = 0; ic_wr = 0; end
      if (p[1] == 1'b0) begin dc_rd = 0; dc_wr = 0; end
      ic_addr = AW'($urandom); ic_wdata = rnd_line();
      dc_addr = AW'($urandom); dc_wdata = rnd_line();
      w_dc = (p == 3) ? !last_dc : (p == 2);
      w_rd = w_dc ? dc_rd : ic_rd;
      w_wr = w_dc ? dc_wr : ic_wr;
      tick();
      lat = $urandom_range(0, 5);
      for (int k = 0; k <= lat; k++) begin
        rd = rnd_line(); mem_rdata = rd; mem_ready = (k == lat);
        @(negedge clk);
        checks++;
        if (all_out !== exp_grant(w_dc, w_rd, w_wr, w_dc ? dc_addr : ic_addr,
                                  w_dc ? dc_wdata : ic_wdata, k == lat, rd)) begin
          errors++;
          $display("FAIL rand%0d_grant: got %h want %s", t, all_out, w_dc ? "DC" : "IC");
        end
        tick();
      end
      ic_rd = 0; ic_wr = 0; dc_rd = 0; dc_wr = 0; mem_ready = 0;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL rand%0d_turn: got %h want 0", t, all_out); end
      tick();
      last_dc = w_dc;
    end
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b want 0", arb_err); end
  endtask

  task automatic test_drop();
    do_reset();
    dc_wr = 1; dc_addr = AW'($urandom); dc_wdata = rnd_line();
    tick();
    tick();
    dc_wr = 0;
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(1, 0, 0, dc_addr, dc_wdata, 0, mem_rdata) || arb_err !== 1'b0) begin
      errors++; $display("FAIL drop_grant: got %h err %b want idle DC grant", all_out, arb_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (all_out !== '0 || arb_err !== 1'b1) begin
      errors++; $display("FAIL drop_turn: got %h err %b want 0 err 1", all_out, arb_err);
    end
    tick();
  endtask

  task automatic test_rw_both();
    logic [DW-1:0] rd;
    do_reset();
    ic_rd = 1; ic_wr = 1; ic_addr = AW'($urandom); ic_wdata = rnd_line();
    tick();
    rd = rnd_line(); mem_rdata = rd; mem_ready = 1;
    @(negedge clk);
    checks++;
    if (all_out !== exp_grant(0, 1, 1, ic_addr, ic_wdata, 1, rd)) begin
      errors++; $display("FAIL rwboth_as_write: got %h want IC write", all_out);
    end
    tick();
    ic_rd = 0; ic_wr = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0 || arb_err !== 1'b1) begin
      errors++; $display("FAIL rwboth_err: got %h err %b want 0 err 1", all_out, arb_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_dc_read();
    test_tie();
    test_back_to_back();
    test_spurious_ready();
    test_timeout();
    test_reset_mid();
    test_random();
    test_drop();
    test_rw_both();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, SHALL set block address width (128-bit line granularity).
REQ-002 Parameter DATA_W, default 128, SHALL set line data width.
REQ-003 Parameter TIMEOUT, default 1023, SHALL set max cycles a grant may wait for mem_ready before error.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 proc_reset_n  in  1  asynchronous, active-low reset.
REQ-006 ic_mem_read, ic_mem_write  in  1 each  instruction-cache request.
REQ-007 ic_mem_addr  in  ADDR_W  ic line address; ic_mem_wdata  in  DATA_W  ic write line.
REQ-008 ic_mem_rdata  out  DATA_W  read line; ic_mem_ready  out  1  ic transaction done.
REQ-009 dc_mem_read, dc_mem_write  in  1 each  data-cache request.
REQ-010 dc_mem_addr  in  ADDR_W; dc_mem_wdata  in  DATA_W  dc address and write line.
REQ-011 dc_mem_rdata  out  DATA_W; dc_mem_ready  out  1  dc read line and completion.
REQ-012 mem_read, mem_write  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  shared memory port.
REQ-013 mem_rdata  in  DATA_W; mem_ready  in  1  shared memory response.
REQ-014 arb_err  out  1  sticky timeout/protocol error flag.

Function
REQ-015 FSM states SHALL be IDLE, GRANT_IC, GRANT_DC, TURN.
REQ-016 A requester is pending when its read or write is high; read and write both high from one requester SHALL be treated as write and set arb_err.
REQ-017 In IDLE with one pending requester, next state SHALL be its GRANT state.
REQ-018 In IDLE with both pending, grant SHALL go to the requester not granted last (round-robin via 1-bit last_grant).
REQ-019 In IDLE nothing pending: stay IDLE; mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
REQ-020 In GRANT_x, mem_read/mem_write/mem_addr/mem_wdata SHALL combinationally mirror requester x's inputs.
REQ-021 In GRANT_x, x_mem_rdata SHALL mirror mem_rdata and x_mem_ready SHALL mirror mem_ready; the non-granted ready SHALL be 0 and its rdata 0.
REQ-022 GRANT_x SHALL persist until mem_ready=1, then go to TURN and update last_grant to x.
REQ-023 TURN SHALL last exactly one cycle with all mem_* outputs 0 and both readies 0, then return to IDLE (lets the cache drop its request).
REQ-024 Arbitration decision uses only registered state plus current requests; grant latency from IDLE = 1 cycle.
REQ-025 If granted requester drops both read and write before mem_ready, FSM SHALL go to TURN next cycle and set arb_err.
REQ-026 Wait counter (width ceil(log2(TIMEOUT+1))) SHALL clear on entry to GRANT_x, increment each GRANT cycle, saturate at TIMEOUT.
REQ-027 Counter reaching TIMEOUT without mem_ready SHALL set arb_err and force TURN.
REQ-028 mem_ready in IDLE or TURN SHALL be ignored and not forwarded.
REQ-029 Requests arriving during GRANT or TURN SHALL wait; no request is lost while held high.
REQ-030 arb_err SHALL clear only on reset.

Reset
REQ-031 Asserting proc_reset_n low SHALL immediately force IDLE, last_grant=DC (so IC wins first tie), counter=0, arb_err=0.
REQ-032 During reset all outputs SHALL be 0; reset mid-transaction abandons it without forwarding mem_ready.
REQ-033 First grant may occur on the first rising edge after reset release.

Verification
REQ-034 dc read addr 0x0000010, mem_ready after 4 cycles with rdata 0xAA..AA -> mem_read=1, mem_addr=0x0000010 throughout, dc_mem_ready pulse 1 cycle, dc_mem_rdata=0xAA..AA, ic_mem_ready=0.
REQ-035 ic read and dc write both raised same cycle after reset -> GRANT_IC first; after its mem_ready, TURN, then GRANT_DC with mem_write=1.
REQ-036 Both requesters held continuously for 4 transactions -> grants alternate IC, DC, IC, DC, each separated by exactly one TURN cycle.
REQ-037 TIMEOUT=7, dc read, mem_ready never asserted -> arb_err=1 after 7 GRANT_DC cycles, TURN then IDLE, arb_err stays 1.
REQ-038 proc_reset_n pulsed low mid GRANT_IC -> outputs 0 asynchronously, no ic_mem_ready, IDLE after release, arb_err=0.
REQ-039 mem_ready=1 spuriously in IDLE with no requests -> both readies stay 0, state stays IDLE.
